// File: rtl/cla_wide_sched_pkg.sv
// rtl/cla_wide_sched_pkg.sv - shared types and helpers for the wide-add sequencer
package cla_wide_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  // Ceiling log2, floored at 1 so a byte index is never zero bits wide.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cla8.sv
// rtl/cla8.sv - 8-bit carry-lookahead adder, every carry expanded from generate/propagate terms
module cla8 (
  output logic       cout,
  output logic [7:0] s,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin
);

  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] c;
  logic       term;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] = cin&p[0..i-1] | OR over j of g[j]&p[j+1..i-1]
  always_comb begin
    c    = '0;
    term = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      term = cin;
      for (int k = 0; k < i; k++) term = term & p[k];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
  end

  assign s    = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/cla_wide_sched.sv
// rtl/cla_wide_sched.sv - two-requester wide adder, one byte per cycle through a shared cla8
module cla_wide_sched
  import cla_wide_sched_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id
);

  localparam int            IW       = clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          id_q, id_d;

  logic          grant;
  logic          accept;
  logic [7:0]    slice_a;
  logic [7:0]    slice_b;
  logic [7:0]    slice_s;
  logic          slice_cout;

  // Contention goes to prio; otherwise whoever is valid. Gated by rst_n so nothing handshakes in reset.
  assign grant      = (req0_valid && req1_valid) ? prio_q : req1_valid;
  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        slice_a = opa_q[i*BYTE_W +: BYTE_W];
        slice_b = opb_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  cla8 u_cla8 (
    .cout (slice_cout),
    .s    (slice_s),
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = grant ? req1_a : req0_a;
          opb_d   = grant ? req1_b : req0_b;
          carry_d = grant ? req1_cin : req0_cin;
          id_d    = grant;
          idx_d   = '0;
          prio_d  = !grant;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) sum_d[i*BYTE_W +: BYTE_W] = slice_s;
        end
        carry_d = slice_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: doc/cla_wide_sched.md
Name: cla_wide_sched

Overview:
- Sequencing controller that runs wide additions (8*NBYTES bits) on one shared 8-bit carry-lookahead adder, one byte per cycle, LSB byte first.
- Carry is chained through a registered carry bit.
- Two requesters share the adder through a round-robin arbiter with valid/ready handshakes.
- A single result port carries the sum and the id of the requester that issued it.

Parameters:
- NBYTES, 4, number of 8-bit slices per operand; legal range 2..8.
- W, 8*NBYTES, operand width; derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_sum  out  W  A+B+cin modulo 2^W.
- rsp_cout  out  1  carry out of bit W-1.
- rsp_id  out  1  requester that issued the result (0/1).

Behaviour:
- Reset (async assert, deassert sampled on clk): state=IDLE, prio=0, byte_idx=0, carry=0, opA/opB/sum regs=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0. reqX_ready are combinational and therefore 0 in reset.
- Reset asserted mid-operation aborts it. No response is produced and the operation is lost.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Grant = the valid requester; if both are valid, grant = prio.
  - reqX_ready = (state==IDLE) && grant==X, combinational from the valid inputs.
  - Ready is never high outside IDLE and never high for both requesters.
- IDLE, on accept (valid&&ready):
  - Latch a, b, cin into opA, opB, carry; latch id.
  - Set byte_idx=0, prio=~grant; go to RUN.
- RUN, per cycle:
  - Shared cla8 gets a=opA[8*byte_idx+:8], b=opB[8*byte_idx+:8], cin=carry.
  - Its s is written into sum[8*byte_idx+:8] and its cout into carry.
  - byte_idx increments each cycle.
  - When byte_idx==NBYTES-1: go to DONE, rsp_cout=final cout, byte_idx=0.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are held stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid=0 next cycle; go to IDLE.
- Latency: accept edge k -> rsp_valid high after edge k+NBYTES.
- Throughput: one operation per NBYTES+2 cycles with rsp_ready tied high. There is no overlap, and IDLE is always visited once between operations.
- Requester behaviour:
  - A requester that drops valid before ready is simply not granted; no error.
  - Operand changes while not ready are ignored.
- Arithmetic: pure unsigned modulo 2^W. There is no overflow flag; signed interpretation is the consumer's job.
- rsp_sum bytes not yet written keep the previous value during RUN. They are visible only internally, because rsp_valid=0.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparam BYTE_W=8;
  - byte_idx width function clog2(NBYTES).
- One sub-module, instantiated once: the team's existing cla8 (ports cout, s, a, b, cin), used unmodified.
- Arbitration stays inline. It is two grant equations plus a prio flop, too small to split out.

Test Plan:
- Carry ripple (NBYTES=4): req0 a=0xFFFFFFFF b=0x00000001 cin=0, rsp_ready=1 -> rsp_valid exactly 4 cycles after accept; sum=0x00000000, cout=1, id=0.
- Carry-in path: req1 a=0x12345678 b=0x11111111 cin=1 -> sum=0x2345678A, cout=0, id=1.
- Arbitration fairness: both valid continuously after reset -> ids alternate 0,1,0,1; req1 alone then both valid -> req0 granted next; ready never high for both.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, req0_ready/req1_ready stay 0; rsp_ready=1 -> rsp_valid drops next cycle and IDLE grants in the following cycle.
- Reset mid-RUN: assert rst_n=0 asynchronously at byte_idx=2 -> all outputs at reset values immediately; no rsp_valid after release; next request completes correctly.
- Random regression: 1000 random a/b/cin with random valid and rsp_ready -> every rsp_sum/rsp_cout equals the reference model {cout,sum}=a+b+cin, and per-id order is preserved.
